// File: rtl/soc_mem_responder_if.sv
// soc_mem_responder_if -- load/store bus between the RV32 core and its memory target.
//   mem_req    initiator -> target  request valid, held with all fields until mem_ack
//   mem_we     initiator -> target  1 = store, 0 = load
//   mem_addr   initiator -> target  byte address, bits [1:0] ignored
//   mem_wdata  initiator -> target  store data, byte lane i = bits [8i+7:8i]
//   mem_wmask  initiator -> target  store byte-lane enables
//   mem_rdata  target -> initiator  load data, valid in the ack cycle, held until next ack
//   mem_ack    target -> initiator  one-cycle completion pulse
interface soc_mem_responder_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/soc_mem_responder.sv
// soc_mem_responder -- memory-mapped target for the RV32 core.
// Word RAM with byte-lane stores plus an I/O page (LED register at word 0,
// free-running cycle counter at word 1, words 2..7 read as zero).
// Every request gets WAIT_STATES extra cycles before a one-cycle mem_ack.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   bus   slave modport of soc_mem_responder_if (request fields in, rdata/ack out)
//   leds  out  5-bit LED register
module soc_mem_responder #(
  parameter int    DEPTH_WORDS = 256,
  parameter int    WAIT_STATES = 1,
  parameter int    IO_BIT      = 22,
  parameter string INIT_FILE   = ""
) (
  input  logic                clk,
  input  logic                rst,
  soc_mem_responder_if.slave  bus,
  output logic [4:0]          leds
);
  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  req_t        lat_req;
  logic [31:0] cyc_cnt;
  logic [31:0] ram [DEPTH_WORDS];

  req_t          cur;
  logic          commit;
  logic          is_io;
  logic [AW-1:0] idx;
  logic [2:0]    io_off;
  logic [31:0]   rd_val;

  // With zero wait states the transaction completes on the same edge that
  // samples it, so the live bus fields stand in for the latched copy.
  always_comb begin
    cur = lat_req;
    if (state == IDLE) cur = {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask};
  end

  // High on the edge that enters RESP: stores commit and load data is captured.
  assign commit = (state == IDLE && bus.mem_req && WAIT_STATES == 0) ||
                  (state == WAIT && wait_cnt == 4'd1);

  assign is_io  = cur.addr[IO_BIT];
  assign idx    = cur.addr[AW+1:2];
  assign io_off = cur.addr[4:2];

  always_comb begin
    rd_val = ram[idx];
    if (is_io) begin
      case (io_off)
        3'd0:    rd_val = {27'b0, leds};
        3'd1:    rd_val = cyc_cnt;
        default: rd_val = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      lat_req       <= '0;
      cyc_cnt       <= '0;
      leds          <= '0;
      bus.mem_ack   <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      cyc_cnt     <= cyc_cnt + 32'd1;
      bus.mem_ack <= 1'b0;
      case (state)
        IDLE: if (bus.mem_req) begin
          lat_req <= cur;
          if (WAIT_STATES == 0) begin
            state       <= RESP;
            bus.mem_ack <= 1'b1;
          end else begin
            state    <= WAIT;
            wait_cnt <= WS;
          end
        end
        // Leave WAIT on the edge where the counter reaches zero, so exactly
        // WAIT_STATES cycles are spent here.
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state       <= RESP;
            bus.mem_ack <= 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit) begin
        if (!cur.we) bus.mem_rdata <= rd_val;
        else if (is_io && io_off == 3'd0 && cur.wmask[0]) leds <= cur.wdata[4:0];
      end
    end
  end

  // RAM has no reset; rst still blocks a store that would land on a reset edge.
  always_ff @(posedge clk) begin
    if (commit && !rst && cur.we && !is_io) begin
      for (int i = 0; i < 4; i++)
        if (cur.wmask[i]) ram[idx][8*i +: 8] <= cur.wdata[8*i +: 8];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{cur.addr[31:AW+2], cur.addr[1:0]};
endmodule
